tone_sequencer: RTL and testbench

Parametrised melody player for the DE2 audio path. It holds a writable note table of (half-period, duration) entries, steps through it at CLOCK_50 rate, and produces a stereo square-wave sample pair for the Audio_Controller `left/right_channel_audio_out` inputs. Compared with the current fixed tone logic, it adds a runtime-loadable song, rests, an end marker, one-shot/loop mode, restart/stop control and status outputs.

---
 rtl/tone_sequencer_if.sv | 48 ++++
 rtl/tone_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_tone_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tone_sequencer_if.sv
// ---------------------------------------------------------------------------
// tone_sequencer_if
// Bundles the control, note-table write and sample/status signals of
// tone_sequencer. The clock and reset stay plain ports on the module.
//   master : drives start/stop/loop and table writes, observes outputs
//   slave  : the sequencer itself
// Signals:
//   start        pulse, (re)start playback from entry 0
//   stop         level, force idle and silence
//   loop         wrap at end of song instead of finishing
//   wr_en        note table write strobe
//   wr_addr      entry to write
//   wr_period    half-period in cycles (0 = rest)
//   wr_duration  note length in cycles (0 = end-of-song marker)
//   sample_left  square-wave sample, two's complement
//   sample_right copy of sample_left
//   playing      high while a song is in progress
//   note_idx     index of the current entry
//   done         one-cycle pulse when a one-shot song ends
// ---------------------------------------------------------------------------
interface tone_sequencer_if #(
  parameter int IDX_W    = 4,
  parameter int CNT_W    = 32,
  parameter int SAMPLE_W = 32
);
  logic                start;
  logic                stop;
  logic                loop;
  logic                wr_en;
  logic [IDX_W-1:0]    wr_addr;
  logic [CNT_W-1:0]    wr_period;
  logic [CNT_W-1:0]    wr_duration;
  logic [SAMPLE_W-1:0] sample_left;
  logic [SAMPLE_W-1:0] sample_right;
  logic                playing;
  logic [IDX_W-1:0]    note_idx;
  logic                done;

  modport master (
    output start, stop, loop, wr_en, wr_addr, wr_period, wr_duration,
    input  sample_left, sample_right, playing, note_idx, done
  );

  modport slave (
    input  start, stop, loop, wr_en, wr_addr, wr_period, wr_duration,
    output sample_left, sample_right, playing, note_idx, done
  );
endinterface

// File: rtl/tone_sequencer.sv
// ---------------------------------------------------------------------------
// tone_sequencer
// Melody player: steps through a writable table of (half-period, duration)
// entries and emits a stereo square-wave sample pair.
// Ports:
//   CLOCK_50  sole clock
//   reset     synchronous, active-high reset
//   bus       tone_sequencer_if.slave (control, table writes, samples, status)
// Optional feature macro: TONE_SEQ_GAP_EN
//   When defined, each note's PLAY is followed by GAP_CYCLES cycles of
//   silence (GAP state, playing stays high) before the next LOAD.
// ---------------------------------------------------------------------------
module tone_sequencer #(
  parameter int NUM_NOTES  = 16,
  parameter int IDX_W      = 4,
  parameter int CNT_W      = 32,
  parameter int SAMPLE_W   = 32,
  parameter int AMPLITUDE  = 100000000,
  parameter int GAP_CYCLES = 1250000
) (
  input logic              CLOCK_50,
  input logic              reset,
  tone_sequencer_if.slave  bus
);

  localparam logic [SAMPLE_W-1:0] AMP_POS  = SAMPLE_W'(AMPLITUDE);
  localparam logic [SAMPLE_W-1:0] AMP_NEG  = SAMPLE_W'(-AMPLITUDE);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_NOTES - 1);
  localparam logic [CNT_W-1:0]    ONE      = CNT_W'(1);

  // Illegal parameter sets elaborate this empty marker block so they are
  // visible in the elaborated hierarchy.
  if ((NUM_NOTES != (1 << IDX_W)) || (GAP_CYCLES < 1) || (SAMPLE_W < 2)) begin : g_bad_params
  end

`ifdef TONE_SEQ_GAP_EN
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_t;
`endif

  // ---------------- note table ----------------
  // Register based because every entry must clear on reset.
  logic [CNT_W-1:0] per_all [NUM_NOTES];
  logic [CNT_W-1:0] dur_all [NUM_NOTES];

  for (genvar gi = 0; gi < NUM_NOTES; gi++) begin : g_entry
    logic [CNT_W-1:0] per_q;
    logic [CNT_W-1:0] dur_q;

    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        per_q <= '0;
        dur_q <= '0;
      end else if (bus.wr_en && (bus.wr_addr == IDX_W'(gi))) begin
        per_q <= bus.wr_period;
        dur_q <= bus.wr_duration;
      end
    end

    assign per_all[gi] = per_q;
    assign dur_all[gi] = dur_q;
  end

  // ---------------- sequencer state ----------------
  state_t              state_q;
  logic [IDX_W-1:0]    note_idx_q;
  logic [CNT_W-1:0]    per_q;
  logic [CNT_W-1:0]    dur_q;
  logic [CNT_W-1:0]    beat_q;
  logic [CNT_W-1:0]    half_q;
  logic                phase_q;
  logic [SAMPLE_W-1:0] sample_q;
  logic                playing_q;
  logic                done_q;
`ifdef TONE_SEQ_GAP_EN
  logic [CNT_W-1:0]    gap_q;
`endif

  // Table read sees the registered contents, so a write landing in the same
  // cycle as LOAD is only visible on a later read.
  logic [CNT_W-1:0] rd_per;
  logic [CNT_W-1:0] rd_dur;
  logic             last_beat;
  logic             half_wrap;

  assign rd_per    = per_all[note_idx_q];
  assign rd_dur    = dur_all[note_idx_q];
  assign last_beat = ((beat_q + ONE) == dur_q);
  assign half_wrap = ((half_q + ONE) == per_q);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= S_IDLE;
      note_idx_q <= '0;
      per_q      <= '0;
      dur_q      <= '0;
      beat_q     <= '0;
      half_q     <= '0;
      phase_q    <= 1'b0;
      sample_q   <= '0;
      playing_q  <= 1'b0;
      done_q     <= 1'b0;
`ifdef TONE_SEQ_GAP_EN
      gap_q      <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (bus.stop) begin
        state_q    <= S_IDLE;
        note_idx_q <= '0;
        sample_q   <= '0;
        playing_q  <= 1'b0;
      end else if (bus.start) begin
        state_q    <= S_LOAD;
        note_idx_q <= '0;
        sample_q   <= '0;
        playing_q  <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            sample_q  <= '0;
            playing_q <= 1'b0;
          end

          S_LOAD: begin
            per_q   <= rd_per;
            dur_q   <= rd_dur;
            beat_q  <= '0;
            half_q  <= '0;
            phase_q <= 1'b0;
            if (rd_dur == '0) begin
              sample_q <= '0;
              if (bus.loop && (note_idx_q != '0)) begin
                // Wrap to the top of the song; stay in LOAD for entry 0.
                note_idx_q <= '0;
                playing_q  <= 1'b1;
              end else begin
                state_q    <= S_IDLE;
                note_idx_q <= '0;
                playing_q  <= 1'b0;
                done_q     <= 1'b1;
              end
            end else begin
              state_q   <= S_PLAY;
              playing_q <= 1'b1;
              // First PLAY cycle already carries the phase-0 level.
              sample_q  <= (rd_per == '0) ? '0 : AMP_POS;
            end
          end

          S_PLAY: begin
            if (last_beat) begin
              sample_q <= '0;
              if ((note_idx_q == LAST_IDX) && !bus.loop) begin
                // Running off the end of the table ends a one-shot song.
                state_q    <= S_IDLE;
                note_idx_q <= '0;
                playing_q  <= 1'b0;
                done_q     <= 1'b1;
              end else begin
                // Index wraps naturally because the table fills the index range.
                note_idx_q <= note_idx_q + IDX_W'(1);
                playing_q  <= 1'b1;
`ifdef TONE_SEQ_GAP_EN
                state_q    <= S_GAP;
                gap_q      <= '0;
`else
                state_q    <= S_LOAD;
`endif
              end
            end else begin
              beat_q <= beat_q + ONE;
              if (half_wrap) begin
                half_q  <= '0;
                phase_q <= ~phase_q;
              end else begin
                half_q <= half_q + ONE;
              end
              // Sample for the next cycle uses the next phase value.
              sample_q <= (per_q == '0) ? '0 :
                          ((phase_q ^ half_wrap) ? AMP_NEG : AMP_POS);
            end
          end

`ifdef TONE_SEQ_GAP_EN
          S_GAP: begin
            sample_q  <= '0;
            playing_q <= 1'b1;
            if ((gap_q + ONE) == CNT_W'(GAP_CYCLES)) begin
              state_q <= S_LOAD;
            end else begin
              gap_q <= gap_q + ONE;
            end
          end
`endif

          default: begin
            state_q   <= S_IDLE;
            sample_q  <= '0;
            playing_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.sample_left  = sample_q;
  assign bus.sample_right = sample_q;
  assign bus.playing      = playing_q;
  assign bus.note_idx     = note_idx_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tone_sequencer
// Self-checking bench for tone_sequencer (default build). A reference model
// expands the note table into the expected per-cycle trace of sample,
// playing, note_idx and done after a start pulse; stop/start interrupts are
// applied by cutting the trace and appending idle cycles or a fresh trace.
// Directed songs are followed by randomized tables, loop changes,
// interrupts and same-cycle table writes.
// ---------------------------------------------------------------------------
module tb_tone_sequencer;

  localparam logic [31:0] A_POS = 32'd100000000;
  localparam logic [31:0] A_NEG = 32'(-100000000);

  logic clk;
  logic reset;

  tone_sequencer_if #(.IDX_W(4), .CNT_W(32), .SAMPLE_W(32)) bus ();

  tone_sequencer #(
    .NUM_NOTES (16),
    .IDX_W     (4),
    .CNT_W     (32),
    .SAMPLE_W  (32),
    .AMPLITUDE (100000000),
    .GAP_CYCLES(1250000)
  ) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] smp;
    logic        play;
    logic [3:0]  idx;
    logic        done;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned tbl_per[16];
  int unsigned tbl_dur[16];
  int unsigned nxt_per[16];
  int unsigned nxt_dur[16];
  bit          pend_en;
  int          pend_a;
  int unsigned pend_p;
  int unsigned pend_d;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void push(input logic [31:0] s, input bit p, input logic [3:0] i, input bit d);
    exp_t e;
    e.smp  = s;
    e.play = p;
    e.idx  = i;
    e.done = d;
    exp_q.push_back(e);
  endfunction

  // A write issued in run cycle 0 is visible to LOADs from cycle 1 on.
  function automatic int unsigned ent_per(input int idx, input int tl);
    if (pend_en && tl >= 1 && idx == pend_a) return pend_p;
    return tbl_per[idx];
  endfunction

  function automatic int unsigned ent_dur(input int idx, input int tl);
    if (pend_en && tl >= 1 && idx == pend_a) return pend_d;
    return tbl_dur[idx];
  endfunction

  function automatic logic [31:0] smp_of(input int unsigned per, input int b);
    if (per == 0) return 32'd0;
    return (((b / per) % 2) == 1) ? A_NEG : A_POS;
  endfunction

  // Appends the trace from run cycle t0 (a fresh start) up to t0+len.
  // loop is high during run cycle x exactly when x < drop.
  function automatic void model(input int t0, input int len, input int drop);
    int idx = 0;
    int t = t0;
    int stop_at = t0 + len;
    int tl;
    int unsigned per, dur;
    bit fin = 0;
    while (t < stop_at && !fin) begin
      tl  = t;
      per = ent_per(idx, tl);
      dur = ent_dur(idx, tl);
      push(32'd0, 1'b1, 4'(idx), 1'b0);
      t++;
      if (dur == 0) begin
        if (tl < drop && idx != 0) begin
          idx = 0;
        end else begin
          push(32'd0, 1'b0, 4'd0, 1'b1);
          t++;
          fin = 1;
        end
      end else begin
        for (int b = 0; b < int'(dur); b++) begin
          push(smp_of(per, b), 1'b1, 4'(idx), 1'b0);
          t++;
        end
        if (idx == 15 && !((t - 1) < drop)) begin
          push(32'd0, 1'b0, 4'd0, 1'b1);
          t++;
          fin = 1;
        end else begin
          idx = (idx + 1) % 16;
        end
      end
    end
    while (t < stop_at) begin
      push(32'd0, 1'b0, 4'd0, 1'b0);
      t++;
    end
    while (exp_q.size() > stop_at) void'(exp_q.pop_back());
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_nxt();
    for (int i = 0; i < 16; i++) begin
      nxt_per[i] = 0;
      nxt_dur[i] = 0;
    end
  endtask

  task automatic write_table();
    for (int i = 0; i < 16; i++) begin
      bus.wr_en       = 1'b1;
      bus.wr_addr     = 4'(i);
      bus.wr_period   = nxt_per[i];
      bus.wr_duration = nxt_dur[i];
      @(negedge clk);
      tbl_per[i] = nxt_per[i];
      tbl_dur[i] = nxt_dur[i];
    end
    bus.wr_en = 1'b0;
  endtask

  // irq_kind: 0 none, 1 stop, 2 start, asserted for run cycle irq_cyc.
  task automatic run(input string name, input int len, input int drop,
                     input int irq_kind, input int irq_cyc,
                     input bit wr_do, input int wr_a,
                     input int unsigned wr_p, input int unsigned wr_d);
    exp_t e;
    int errs0 = n_errors;
    exp_q.delete();
    pend_en = wr_do;
    pend_a  = wr_a;
    pend_p  = wr_p;
    pend_d  = wr_d;
    model(0, len, drop);
    if (irq_kind != 0) begin
      while (exp_q.size() > irq_cyc + 1) void'(exp_q.pop_back());
      if (irq_kind == 1) begin
        while (exp_q.size() < len) push(32'd0, 1'b0, 4'd0, 1'b0);
      end else begin
        model(irq_cyc + 1, len - irq_cyc - 1, drop);
      end
    end
    bus.wr_addr     = 4'(wr_a);
    bus.wr_period   = wr_p;
    bus.wr_duration = wr_d;
    bus.loop        = (drop > 0);
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int t = 0; t < len; t++) begin
      e = exp_q[t];
      check($sformatf("%s t%0d sample", name, t),
            64'({bus.sample_left, bus.sample_right}), 64'({e.smp, e.smp}));
      check($sformatf("%s t%0d play/idx/done", name, t),
            64'({bus.playing, bus.note_idx, bus.done}), 64'({e.play, e.idx, e.done}));
      bus.loop  = (t < drop);
      bus.stop  = (irq_kind == 1 && t == irq_cyc);
      bus.start = (irq_kind == 2 && t == irq_cyc);
      bus.wr_en = (wr_do && t == 0);
      @(negedge clk);
    end
    bus.loop  = 1'b0;
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    if (wr_do) begin
      tbl_per[wr_a] = wr_p;
      tbl_dur[wr_a] = wr_d;
    end
    $display("run %-10s len=%0d drop=%0d irq=%0d@%0d wr=%0d errors=%0d",
             name, len, drop, irq_kind, irq_cyc, wr_do, n_errors - errs0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int len, mode, drop, irq_kind, irq_cyc;
    bit wr_do;

    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.loop        = 1'b0;
    // A write pending during reset must be ignored.
    bus.wr_en       = 1'b1;
    bus.wr_addr     = 4'd0;
    bus.wr_period   = 32'd7;
    bus.wr_duration = 32'd9;
    for (int i = 0; i < 16; i++) begin
      tbl_per[i] = 0;
      tbl_dur[i] = 0;
    end
    repeat (3) @(negedge clk);
    reset     = 1'b0;
    bus.wr_en = 1'b0;
    check("reset sample_left",  64'(bus.sample_left),  64'd0);
    check("reset sample_right", 64'(bus.sample_right), 64'd0);
    check("reset playing",      64'(bus.playing),      64'd0);
    check("reset note_idx",     64'(bus.note_idx),     64'd0);
    check("reset done",         64'(bus.done),         64'd0);
    $display("reset checked");

    // Empty table: done two cycles after start, no sound.
    run("empty", 6, 0, 0, 0, 1'b0, 0, 0, 0);

    // Single tone then end marker.
    clear_nxt();
    nxt_per[0] = 4; nxt_dur[0] = 20;
    write_table();
    run("tone", 30, 0, 0, 0, 1'b0, 0, 0, 0);

    // Stop mid-note.
    run("stop", 14, 0, 1, 6, 1'b0, 0, 0, 0);

    // Rest then tone.
    clear_nxt();
    nxt_per[0] = 0; nxt_dur[0] = 10;
    nxt_per[1] = 3; nxt_dur[1] = 6;
    write_table();
    run("rest", 24, 0, 0, 0, 1'b0, 0, 0, 0);

    // Two-note loop, loop dropped later.
    clear_nxt();
    nxt_per[0] = 2; nxt_dur[0] = 3;
    nxt_per[1] = 1; nxt_dur[1] = 4;
    write_table();
    run("loop", 70, 40, 0, 0, 1'b0, 0, 0, 0);

    // Restart while playing index 3.
    clear_nxt();
    nxt_per[0] = 1; nxt_dur[0] = 2;
    nxt_per[1] = 2; nxt_dur[1] = 2;
    nxt_per[2] = 3; nxt_dur[2] = 2;
    nxt_per[3] = 1; nxt_dur[3] = 5;
    write_table();
    run("restart", 30, 0, 2, 11, 1'b0, 0, 0, 0);

    // Full table, end by running off entry 15.
    clear_nxt();
    for (int i = 0; i < 16; i++) begin
      nxt_per[i] = $urandom_range(1, 4);
      nxt_dur[i] = 5;
    end
    write_table();
    run("full", 100, 0, 0, 0, 1'b0, 0, 0, 0);

    // Write to entry 0 in the LOAD cycle: first pass plays old contents.
    clear_nxt();
    nxt_per[0] = 2; nxt_dur[0] = 4;
    write_table();
    run("wr_load", 10, 0, 0, 0, 1'b1, 0, 5, 9);
    run("wr_after", 14, 0, 0, 0, 1'b0, 0, 0, 0);

    // Randomized songs.
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 16; i++) begin
        nxt_dur[i] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 8);
        nxt_per[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 5);
      end
      write_table();
      len  = $urandom_range(40, 200);
      mode = $urandom_range(0, 2);
      drop = (mode == 0) ? 0 : (mode == 1) ? len : $urandom_range(1, len - 1);
      irq_kind = $urandom_range(0, 3);
      if (irq_kind == 3) irq_kind = 0;
      irq_cyc = $urandom_range(0, len - 2);
      wr_do = 1'($urandom_range(0, 1));
      run($sformatf("rand%0d", r), len, drop, irq_kind, irq_cyc, wr_do,
          $urandom_range(0, 15), $urandom_range(0, 5), $urandom_range(0, 8));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
